zbb_count_unit: RTL and testbench
=================================

Name: zbb_count_unit

Overview:
Pipelined execute-stage unit for the Zbb count instructions cpop, clz and ctz. It conditions the rs1 operand so that all three operations reduce to a single population count, then feeds the existing single-cycle cpop bit counter (32-bit in, 6-bit out). The result is zero-extended to 32 bits and presented to writeback through a valid/ready handshake. The unit has two register stages, backpressure and a flush input.

Parameters:
XLEN, 32, operand/result width; only 32 supported
TAG_W, 5, destination register tag width (rd)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline kill; drops all in-flight ops
in_valid  in  1  request valid
in_ready  out  1  unit accepts request this cycle
in_op  in  2  00=cpop, 01=clz, 10=ctz, 11=reserved
in_rs1  in  XLEN  source operand
in_rd  in  TAG_W  destination tag, carried alongside the op
out_valid  out  1  result valid
out_ready  in  1  writeback accepts result
out_result  out  XLEN  zero-extended count, range 0..32
out_rd  out  TAG_W  tag of the result
out_illegal  out  1  op was reserved (11); out_result is 0
busy  out  1  either stage holds a valid op

Behaviour:
- Reset (async assert, sync deassert by integrator): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_rd=0, out_illegal=0, busy=0. in_ready=1 after reset unless flush is high.
- Transfer on input when in_valid & in_ready. Transfer on output when out_valid & out_ready.
- Stage 1 (S1) register latches the conditioned operand m, plus op, rd and illegal:
  - cpop: m = rs1.
  - ctz: m = ~rs1 & (rs1 - 1), with 32-bit wrap.
  - clz: r = bit-reverse(rs1), then m = ~r & (r - 1).
  - reserved: m = 0, illegal = 1.
- Stage 2 (S2) register latches {26'b0, cpop(m)}, rd and illegal. S2 drives the out_* ports directly.
- Latency: with no backpressure, an op accepted at edge N has out_valid=1 after edge N+2. Throughput is 1 op/cycle.
- Advance rules:
  - s2_load = s1_valid & (~s2_valid | out_ready).
  - s1_load = in_valid & in_ready.
  - in_ready = ~flush & (~s1_valid | s2_load).
  - S1 clears when s2_load occurs without s1_load. S2 clears on an output transfer without s2_load.
- Order: strictly in order. No op is dropped or duplicated under any out_ready pattern. Output payload stays stable while out_valid=1 and out_ready=0.
- Flush:
  - At the next edge, s1_valid=0 and s2_valid=0.
  - in_ready=0 during the flush cycle, so no op is accepted.
  - Any output transfer in the flush cycle still counts as completed.
  - Data registers need not clear.
- Boundaries:
  - rs1=0 gives ctz=32 and clz=32; this falls naturally out of the mask, which becomes all ones.
  - rs1=0xFFFFFFFF gives cpop=32, ctz=0, clz=0.
  - Both stages full with out_ready=0 gives in_ready=0.
  - Both stages full with out_ready=1 gives simultaneous S2 drain, S1→S2 move and new S1 accept.
- Reset mid-operation: all valid bits drop immediately and asynchronously; in-flight ops are lost.
- busy = s1_valid | s2_valid.

Test Plan:
- Reset with ops in flight: assert reset_n=0 while both stages are valid -> out_valid=0 and busy=0 immediately; in_ready=1 after release.
- Basic latency: cpop 0xFFFFFFFF, clz 0x00010000, ctz 0x00010000 issued back-to-back with out_ready=1 -> results 32, 15, 16 on consecutive cycles, first at 2 cycles after accept, rd tags matching.
- Zero and extreme operands: clz 0 -> 32; ctz 0 -> 32; clz 0x80000000 -> 0; ctz 0x80000000 -> 31; cpop 0xA5A5A5A5 -> 16.
- Backpressure: hold out_ready=0 and offer 3 ops -> in_ready drops after 2 accepts and out_* stays stable. Release out_ready -> all 3 results emerge in order with none lost.
- Flush: flush=1 with both stages valid and in_valid=1 -> no accept that cycle; next cycle out_valid=0 and busy=0. The following op completes normally.
- Reserved op 11 with rs1=0x1234 -> out_illegal=1 and out_result=0. The next cpop 0x0000000F -> out_illegal=0 and out_result=4.

Source files
------------

// File: rtl/zbb_count_unit_if.sv
// Request/response bundle between the count unit and issue/writeback.
interface zbb_count_unit_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [XLEN-1:0]  in_rs1;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_rs1, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_illegal
  );
endinterface

// File: rtl/zbb_count_unit.sv
// Zbb cpop/clz/ctz execute unit. The operand is masked in S1 so every op
// becomes a population count, which S2 computes and holds for writeback.
module zbb_count_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  zbb_count_unit_if.slave  bus,
  output logic             busy
);
  localparam int CNT_W = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    OP_CPOP = 2'b00,
    OP_CLZ  = 2'b01,
    OP_CTZ  = 2'b10,
    OP_RSV  = 2'b11
  } op_e;

  logic             s1_valid, s2_valid;
  logic [XLEN-1:0]  s1_m;
  logic [TAG_W-1:0] s1_rd, s2_rd;
  logic             s1_ill, s2_ill;
  logic [XLEN-1:0]  s2_res;

  logic             s1_load, s2_load;
  logic [XLEN-1:0]  rev, m;
  logic             ill;
  logic [CNT_W-1:0] cnt;

  assign s2_load     = s1_valid & (~s2_valid | bus.out_ready);
  assign s1_load     = bus.in_valid & bus.in_ready;
  assign bus.in_ready = ~flush & (~s1_valid | s2_load);

  // Condition rs1: ctz counts the ones below the lowest set bit; clz is ctz of the reversed word.
  always_comb begin
    rev = '0;
    for (int i = 0; i < XLEN; i++) rev[i] = bus.in_rs1[XLEN-1-i];
    m   = '0;
    ill = 1'b0;
    case (bus.in_op)
      OP_CPOP: m = bus.in_rs1;
      OP_CLZ:  m = ~rev & (rev - XLEN'(1));
      OP_CTZ:  m = ~bus.in_rs1 & (bus.in_rs1 - XLEN'(1));
      default: ill = 1'b1;
    endcase
  end

  // Population count of the conditioned operand held in S1.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < XLEN; i++) cnt = cnt + CNT_W'(s1_m[i]);
  end

  // S1: accept a new op, or empty out when its op moves on to S2.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_rd    <= '0;
      s1_ill   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_m     <= m;
      s1_rd    <= bus.in_rd;
      s1_ill   <= ill;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: take the count from S1, or empty out after writeback takes the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_rd    <= '0;
      s2_ill   <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      s2_res   <= {{(XLEN-CNT_W){1'b0}}, cnt};
      s2_rd    <= s1_rd;
      s2_ill   <= s1_ill;
    end else if (bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign bus.out_valid   = s2_valid;
  assign bus.out_result  = s2_res;
  assign bus.out_rd      = s2_rd;
  assign bus.out_illegal = s2_ill;
  assign busy            = s1_valid | s2_valid;
endmodule

// File: tb/tb_zbb_count_unit.sv
// Bench for zbb_count_unit: directed steps plus random traffic against a
// scoreboard fed by a bit-scanning reference model.
module tb_zbb_count_unit;
  logic clk, reset_n, flush, busy;
  zbb_count_unit_if #(.XLEN(32), .TAG_W(5)) bus ();

  zbb_count_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        ill;
    int          acc;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0, cyc_n = 0, acc_cnt = 0;
  bit chk_lat = 0, prev_hold = 0;
  logic [31:0] prev_res;
  logic [4:0]  prev_rd;
  logic        prev_ill;

  // Reference: count bits by scanning the operand directly.
  function automatic logic [31:0] ref_res(logic [1:0] op, logic [31:0] v);
    int n = 0;
    case (op)
      2'b00: for (int i = 0; i < 32; i++) n += int'(v[i]);
      2'b01: for (int i = 31; i >= 0; i--) begin if (v[i]) break; n++; end
      2'b10: for (int i = 0; i < 32; i++) begin if (v[i]) break; n++; end
      default: n = 0;
    endcase
    return 32'(n);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(logic v, logic [1:0] op, logic [31:0] rs1, logic [4:0] rd);
    bus.in_valid = v; bus.in_op = op; bus.in_rs1 = rs1; bus.in_rd = rd;
  endtask

  // One clock: score transfers seen before the edge, then advance.
  task automatic cyc();
    bit fl;
    exp_t e;
    #1;
    if (prev_hold) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_res", bus.out_result, prev_res);
      chk("hold_rd", 32'(bus.out_rd), 32'(prev_rd));
      chk("hold_ill", 32'(bus.out_illegal), 32'(prev_ill));
    end
    if (bus.out_valid && bus.out_ready) begin
      chk("spurious_out", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("result", bus.out_result, e.res);
        chk("rd", 32'(bus.out_rd), 32'(e.rd));
        chk("illegal", 32'(bus.out_illegal), 32'(e.ill));
        if (chk_lat) chk("latency", 32'(cyc_n - e.acc), 32'd2);
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e.res = ref_res(bus.in_op, bus.in_rs1);
      e.rd  = bus.in_rd;
      e.ill = (bus.in_op == 2'b11);
      e.acc = cyc_n;
      q.push_back(e);
      acc_cnt++;
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_res = bus.out_result; prev_rd = bus.out_rd; prev_ill = bus.out_illegal;
    fl = flush;
    @(posedge clk);
    cyc_n++;
    if (fl) begin q.delete(); prev_hold = 0; end
    #1;
  endtask

  task automatic drain(int n);
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    chk("drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back basic ops, latency 2.
    chk_lat = 1; bus.out_ready = 1'b1;
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 5'd1); cyc();
    drive(1'b1, 2'b01, 32'h0001_0000, 5'd2); cyc();
    drive(1'b1, 2'b10, 32'h0001_0000, 5'd3); cyc();
    drain(4);

    // Zero and extreme operands.
    drive(1'b1, 2'b01, 32'h0, 5'd4); cyc();
    drive(1'b1, 2'b10, 32'h0, 5'd5); cyc();
    drive(1'b1, 2'b01, 32'h8000_0000, 5'd6); cyc();
    drive(1'b1, 2'b10, 32'h8000_0000, 5'd7); cyc();
    drive(1'b1, 2'b00, 32'hA5A5_A5A5, 5'd8); cyc();
    drive(1'b1, 2'b10, 32'hFFFF_FFFF, 5'd9); cyc();
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 5'd10); cyc();
    drain(4);
    chk_lat = 0;

    // Backpressure: two accepts fill the pipe, then the third waits.
    bus.out_ready = 1'b0;
    acc_cnt = 0;
    drive(1'b1, 2'b00, 32'h0000_00FF, 5'd11); cyc();
    drive(1'b1, 2'b01, 32'h0000_0100, 5'd12); cyc();
    drive(1'b1, 2'b10, 32'h0000_0100, 5'd13); cyc();
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    cyc(); cyc(); cyc();
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && acc_cnt < 3; i++) cyc();
    chk("bp_third_accept", 32'(acc_cnt), 32'd3);
    drain(4);

    // Flush with both stages full and a request pending.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h0000_0007, 5'd14); cyc();
    drive(1'b1, 2'b00, 32'h0000_0003, 5'd15); cyc();
    chk("pre_flush_busy", 32'(busy), 32'd1);
    drive(1'b1, 2'b00, 32'h0000_0001, 5'd16);
    flush = 1'b1;
    acc_cnt = 0;
    #1 chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk("flush_accepts", 32'(acc_cnt), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_0008, 5'd17); cyc();
    drain(4);

    // Reserved op, then a normal cpop.
    drive(1'b1, 2'b11, 32'h0000_1234, 5'd18); cyc();
    drive(1'b1, 2'b00, 32'h0000_000F, 5'd19); cyc();
    drain(4);

    // Asynchronous reset with both stages valid.
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 32'h1, 5'd20); cyc();
    drive(1'b1, 2'b00, 32'h3, 5'd21); cyc();
    drive(1'b0, 2'b00, 32'h0, 5'd0);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    q.delete(); prev_hold = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);

    // Random traffic with random backpressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] v;
      case ($urandom_range(0, 5))
        0: v = 32'h0;
        1: v = 32'hFFFF_FFFF;
        2: v = 32'h1 << $urandom_range(0, 31);
        default: v = $urandom;
      endcase
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), v, 5'($urandom));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 29) == 0);
      cyc();
    end
    flush = 1'b0;
    drain(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
